// File: rtl/mac_array_engine_if.sv
// Command/operand/result bundle for mac_array_engine.
// master drives commands and operands; slave is the engine.
interface mac_array_engine_if #(
  parameter int PARA   = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
);
  logic                     start;
  logic [2:0]               op_type;
  logic [CNT_W-1:0]         op_num;
  logic [4:0]               avg_shift;
  logic [PARA*DATA_W-1:0]   bias;
  logic                     in_valid;
  logic                     in_ready;
  logic [PARA*DATA_W-1:0]   in_data;
  logic [PARA*DATA_W-1:0]   in_weight;
  logic                     out_valid;
  logic                     out_ready;
  logic [PARA*DATA_W-1:0]   out_data;
  logic                     busy;
  logic                     err_op;

  modport master (
    output start, op_type, op_num, avg_shift, bias, in_valid, in_data, in_weight, out_ready,
    input  in_ready, out_valid, out_data, busy, err_op
  );
  modport slave (
    input  start, op_type, op_num, avg_shift, bias, in_valid, in_data, in_weight, out_ready,
    output in_ready, out_valid, out_data, busy, err_op
  );
endinterface

// File: rtl/mac_array_engine.sv
// PARA-lane fixed-point MAC / max-pool / avg-pool engine with IDLE/RUN/DONE control.
// Define ENGINE_SAT_EN to saturate lane results to DATA_W instead of wrapping.
module mac_lane #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic                     beat,
  input  logic [2:0]               mode,
  input  logic [4:0]               shift,
  input  logic signed [DATA_W-1:0] bias,
  input  logic signed [DATA_W-1:0] data,
  input  logic signed [DATA_W-1:0] weight,
  output logic [DATA_W-1:0]        res
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc, acc_nxt, init_val, dext, pext, wide;

  assign prod = data * weight;
  assign pext = ACC_W'(prod);
  assign dext = ACC_W'(data);

  always_comb begin
    case (mode)
      3'd4:    init_val = {1'b1, {(ACC_W-1){1'b0}}};
      3'd5:    init_val = '0;
      default: init_val = ACC_W'(bias) <<< FRAC_W;
    endcase
  end

  // Result is derived from the next accumulator value so the top can
  // register it on the same edge that consumes the final beat.
  always_comb begin
    acc_nxt = acc;
    if (init) acc_nxt = init_val;
    else if (beat) begin
      case (mode)
        3'd4:    acc_nxt = (dext > acc) ? dext : acc;
        3'd5:    acc_nxt = acc + dext;
        default: acc_nxt = acc + pext;
      endcase
    end
    case (mode)
      3'd4:    wide = acc_nxt;
      3'd5:    wide = acc_nxt >>> shift;
      default: wide = acc_nxt >>> FRAC_W;
    endcase
  end

`ifdef ENGINE_SAT_EN
  always_comb begin
    if ((&wide[ACC_W-1:DATA_W-1]) || ~(|wide[ACC_W-1:DATA_W-1]))
      res = wide[DATA_W-1:0];
    else if (wide[ACC_W-1])
      res = {1'b1, {(DATA_W-1){1'b0}}};
    else
      res = {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  logic unused_hi;
  assign unused_hi = ^wide[ACC_W-1:DATA_W];
  assign res = wide[DATA_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else     acc <= acc_nxt;
  end
endmodule

module mac_array_engine #(
  parameter int PARA   = 16,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 32
) (
  input logic               clk,
  input logic               rst,
  mac_array_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                         state;
  logic [2:0]                     op_q, mode;
  logic [4:0]                     shift_q, shift;
  logic [CNT_W-1:0]               num_q, cnt;
  logic                           err_q, legal, go, take, last;
  logic [PARA-1:0][DATA_W-1:0]    bias_v, data_v, wgt_v, lane_res, out_q;

  assign bias_v = bus.bias;
  assign data_v = bus.in_data;
  assign wgt_v  = bus.in_weight;

  assign legal = (bus.op_type >= 3'd1) && (bus.op_type <= 3'd5);
  assign go    = (state == IDLE) && bus.start && legal;
  assign take  = (state == RUN) && bus.in_valid;
  assign last  = take && ((cnt + CNT_W'(1)) == num_q);

  // Lanes see the incoming command while idle so init happens on the start edge.
  assign mode  = (state == IDLE) ? bus.op_type   : op_q;
  assign shift = (state == IDLE) ? bus.avg_shift : shift_q;

  for (genvar k = 0; k < PARA; k++) begin : g_lane
    mac_lane #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .init   (go),
      .beat   (take),
      .mode   (mode),
      .shift  (shift),
      .bias   (bias_v[k]),
      .data   (data_v[k]),
      .weight (wgt_v[k]),
      .res    (lane_res[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      err_q   <= 1'b0;
      out_q   <= '0;
      cnt     <= '0;
      num_q   <= '0;
      op_q    <= '0;
      shift_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          if (legal) begin
            op_q    <= bus.op_type;
            shift_q <= bus.avg_shift;
            num_q   <= bus.op_num;
            cnt     <= '0;
            if (bus.op_num == '0) begin
              state <= DONE;
              out_q <= lane_res;
            end else begin
              state <= RUN;
            end
          end else begin
            err_q <= 1'b1;
          end
        end
        RUN: if (take) begin
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            state <= DONE;
            out_q <= lane_res;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == RUN);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.err_op    = err_q;
  assign bus.out_data  = out_q;
endmodule

// File: tb/tb_mac_array_engine.sv
// Directed table-driven bench for mac_array_engine plus hand-written handshake/reset sequences.
module tb_mac_array_engine;
  localparam int PARA = 16, DATA_W = 16, FRAC_W = 8, ACC_W = 40, CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_array_engine_if #(.PARA(PARA), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus();
  mac_array_engine #(.PARA(PARA), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .CNT_W(CNT_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    int          n;
    logic [4:0]  sh;
    logic [15:0] bias, d0, step, w, exp;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(input string name, input logic [2:0] op, input int n,
                              input logic [4:0] sh, input logic [15:0] bias, d0, step, w, exp);
    vec_t v;
    v.name = name; v.op = op; v.n = n; v.sh = sh;
    v.bias = bias; v.d0 = d0; v.step = step; v.w = w; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_lanes(input string name, input logic [PARA-1:0][15:0] exp);
    logic [PARA-1:0][15:0] got;
    int bad;
    got = bus.out_data;
    bad = -1;
    for (int k = PARA - 1; k >= 0; k--) if (got[k] !== exp[k]) bad = k;
    total++;
    if (bad < 0) passed++;
    else $display("FAIL %s lane %0d: got %0h expected %0h", name, bad, got[bad], exp[bad]);
  endtask

  task automatic issue(input logic [2:0] op, input int n, input logic [4:0] sh, input logic [15:0] b);
    bus.start     = 1'b1;
    bus.op_type   = op;
    bus.op_num    = CNT_W'(n);
    bus.avg_shift = sh;
    bus.bias      = {PARA{b}};
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] d;
    issue(v.op, v.n, v.sh, v.bias);
    check({v.name, " busy"}, 32'(bus.busy), 32'd1);
    d = v.d0;
    for (int i = 0; i < v.n; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = {PARA{d}};
      bus.in_weight = {PARA{v.w}};
      @(negedge clk);
      d = d + v.step;
    end
    bus.in_valid = 1'b0;
    check({v.name, " out_valid"}, 32'(bus.out_valid), 32'd1);
    check_lanes({v.name, " data"}, {PARA{v.exp}});
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({v.name, " idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [PARA-1:0][15:0] dv, mexp;
    logic [15:0] mseq[4];
    logic seen;

    tbl[0] = mk("conv3",   3'd2, 9, 5'd0, 16'h0080, 16'h0100, 16'h0000, 16'h0200, 16'h1280);
    tbl[1] = mk("apool",   3'd5, 4, 5'd2, 16'h0000, 16'h0004, 16'h0004, 16'h0000, 16'h000A);
    tbl[2] = mk("apool0",  3'd5, 0, 5'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
`ifdef ENGINE_SAT_EN
    tbl[3] = mk("conv1sat", 3'd1, 4, 5'd0, 16'h0000, 16'h7F00, 16'h0000, 16'h7F00, 16'h7FFF);
    tbl[4] = mk("mpool0",   3'd4, 0, 5'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000);
`else
    tbl[3] = mk("conv1sat", 3'd1, 4, 5'd0, 16'h0000, 16'h7F00, 16'h0000, 16'h7F00, 16'h0400);
    tbl[4] = mk("mpool0",   3'd4, 0, 5'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
`endif
    tbl[5] = mk("conv1neg", 3'd1, 2, 5'd0, 16'h0100, 16'hFF00, 16'h0000, 16'h0300, 16'hFB00);
    tbl[6] = mk("convp",    3'd3, 3, 5'd0, 16'h0000, 16'h0080, 16'h0000, 16'h0080, 16'h00C0);
    tbl[7] = mk("apoolneg", 3'd5, 3, 5'd0, 16'h0000, 16'hFFFB, 16'h0000, 16'h0000, 16'hFFF1);
    tbl[8] = mk("mpoolneg", 3'd4, 3, 5'd0, 16'h0000, 16'hFFF0, 16'h0001, 16'h0000, 16'hFFF2);
    tbl[9] = mk("apoolsh",  3'd5, 2, 5'd1, 16'h0000, 16'hFFF9, 16'h0000, 16'h0000, 16'hFFF9);

    rst = 1'b1;
    bus.start = 1'b0; bus.op_type = '0; bus.op_num = '0; bus.avg_shift = '0; bus.bias = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_weight = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst in_ready",  32'(bus.in_ready),  32'd0);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst busy",      32'(bus.busy),      32'd0);
    check("rst err_op",    32'(bus.err_op),    32'd0);
    check_lanes("rst out_data", '0);

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    // MPOOL with distinct lanes, then a stalled result with ignored start/in_valid.
    mseq[0] = 16'hFFFD; mseq[1] = 16'h0007; mseq[2] = 16'h0002; mseq[3] = 16'hFFFF;
    for (int k = 0; k < PARA; k++) mexp[k] = 16'(k);
    mexp[0] = 16'h0007;
    issue(3'd4, 4, 5'd0, 16'h0000);
    check("mpool in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < PARA; k++) dv[k] = 16'(k);
      dv[0] = mseq[i];
      bus.in_valid = 1'b1;
      bus.in_data  = dv;
      @(negedge clk);
    end
    bus.in_data = {PARA{16'h7000}};
    bus.start = 1'b1; bus.op_type = 3'd5; bus.op_num = CNT_W'(1);
    for (int c = 0; c < 5; c++) begin
      check("hold out_valid", 32'(bus.out_valid), 32'd1);
      check("hold in_ready",  32'(bus.in_ready),  32'd0);
      check_lanes("hold data", mexp);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    check("start at handshake ignored", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("still idle", 32'(bus.busy), 32'd0);

    // Illegal op types.
    issue(3'd6, 4, 5'd0, 16'h0000);
    check("err6 pulse", 32'(bus.err_op), 32'd1);
    check("err6 busy",  32'(bus.busy),   32'd0);
    @(negedge clk);
    check("err6 once",  32'(bus.err_op), 32'd0);
    issue(3'd0, 4, 5'd0, 16'h0000);
    check("err0 pulse", 32'(bus.err_op), 32'd1);

    // Reset mid-RUN after 3 of 9 beats.
    issue(3'd2, 9, 5'd0, 16'h0080);
    bus.in_data = {PARA{16'h0100}}; bus.in_weight = {PARA{16'h0200}};
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy",     32'(bus.busy),     32'd0);
    check("abort in_ready", 32'(bus.in_ready), 32'd0);
    check_lanes("abort out_data", '0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (bus.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("abort no out_valid", 32'(seen), 32'd0);

    run_vec(mk("after_rst", 3'd5, 1, 5'd0, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 16'h0005));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
